// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared receiver state encodings and frame constants.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 4;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo: FIFO_DEPTH x 8 byte queue, combinational head read.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core: 8N1 UART receiver feeding a byte FIFO; define UART_RX_PARITY_EN
// for an even-parity bit after bit 7 and a sticky parity_err output.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] clk_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  input  logic             err_clr
);

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push, frame_set, overrun_set;
  logic             fifo_full, fifo_empty, pop;
  logic [DIV_W-1:0] div_eff, half_m1, full_m1;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d, par_set, parity_err_q;
`endif
  logic             frame_err_q, overrun_q;

  assign div_eff = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
  assign half_m1 = (div_q >> 1) - DIV_W'(1);
  assign full_m1 = div_q - DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(MIN_DIV);
      idx_q     <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DIV_W'(1);
    div_d     = div_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s_q) begin
          state_d = ST_START;
          div_d   = div_eff;
        end
      end
      ST_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt_q == half_m1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == full_m1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == full_m1) begin
          cnt_d     = '0;
          par_bad_d = (rx_s_q != even_parity(shift_q));
          par_set   = par_bad_d;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == full_m1) begin
          cnt_d = '0;
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pop         = rx_valid && rx_ready;
  assign overrun_set = push && fifo_full && !pop;

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= frame_set   || (frame_err_q  && !err_clr);
      overrun_q    <= overrun_set || (overrun_q    && !err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err_q <= par_set     || (parity_err_q && !err_clr);
`endif
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign rx_busy   = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core: directed bench for uart_rx_core at clk_div=16.  Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_core;

  localparam int DIV = 16;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx       = 1'b1;
  logic        rx_ready = 1'b1;
  logic        err_clr  = 1'b0;
  logic [15:0] clk_div  = 16'(DIV);
  logic [7:0]  rx_data;
  logic        rx_valid, rx_busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int first_valid = -1;
  int fall_cyc = 0;
  logic [7:0] got[$];

  uart_rx_core #(
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .clk_div    (clk_div),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every handshake and how long rx_valid stays up.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (rx_valid && rx_ready) got.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic has_par,
                            input logic par);
    rx = 1'b0;
    fall_cyc = cyc;
    wait_clk(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(DIV);
    end
    if (has_par) begin
      rx = par;
      wait_clk(DIV);
    end
    rx = stop;
    wait_clk(DIV);
  endtask

  initial begin
    wait_clk(3);
    @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(5);

    // 1: single byte, latency = 2 sync + 8 start + 8*16 data + 16 stop + 1
    valid_cycles = 0;
    first_valid = -1;
    got.delete();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_clk(5);
    @(negedge clk);
    check("t1_count", 32'(got.size()), 32'd1);
    check("t1_data", 32'(got[0]), 32'hA5);
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("t1_latency", 32'(first_valid - fall_cyc), 32'd155);
    check("t1_busy", 32'(rx_busy), 32'h0);
    check("t1_frame_err", 32'(frame_err), 32'h0);

    // 2: short glitch on rx
    wait_clk(1);
    got.delete();
    valid_cycles = 0;
    rx = 1'b0;
    wait_clk(5);
    rx = 1'b1;
    @(negedge clk);
    check("t2_busy_during", 32'(rx_busy), 32'h1);
    wait_clk(20);
    @(negedge clk);
    check("t2_busy_after", 32'(rx_busy), 32'h0);
    check("t2_no_valid", 32'(valid_cycles), 32'd0);
    check("t2_frame_err", 32'(frame_err), 32'h0);
    check("t2_overrun", 32'(overrun), 32'h0);

    // 3: bad stop bit, line held low, then a good byte
    wait_clk(1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_clk(40);
    rx = 1'b1;
    wait_clk(10);
    @(negedge clk);
    check("t3_frame_err", 32'(frame_err), 32'h1);
    check("t3_dropped", 32'(got.size()), 32'd0);
    check("t3_busy_idle", 32'(rx_busy), 32'h0);
    wait_clk(1);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_clk(5);
    @(negedge clk);
    check("t3_count", 32'(got.size()), 32'd1);
    check("t3_data", 32'(got[0]), 32'h5A);
    check("t3_err_sticky", 32'(frame_err), 32'h1);
    wait_clk(1);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("t3_err_clr", 32'(frame_err), 32'h0);

    // 4: overflow the 4-deep FIFO, then drain
    wait_clk(1);
    got.delete();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      wait_clk(2);
    end
    @(negedge clk);
    check("t4_overrun", 32'(overrun), 32'h1);
    check("t4_valid", 32'(rx_valid), 32'h1);
    check("t4_head", 32'(rx_data), 32'h01);
    wait_clk(1);
    rx_ready = 1'b1;
    wait_clk(8);
    rx_ready = 1'b0;
    @(negedge clk);
    check("t4_drain_count", 32'(got.size()), 32'd4);
    check("t4_drain0", 32'(got[0]), 32'h01);
    check("t4_drain1", 32'(got[1]), 32'h02);
    check("t4_drain2", 32'(got[2]), 32'h03);
    check("t4_drain3", 32'(got[3]), 32'h04);
    check("t4_empty", 32'(rx_valid), 32'h0);

    // 5: reset in the middle of 0xFF, then a clean 0x81
    wait_clk(1);
    rx_ready = 1'b1;
    got.delete();
    rx = 1'b0;
    wait_clk(DIV);
    rx = 1'b1;
    wait_clk(40);
    @(negedge clk);
    check("t5_busy_pre", 32'(rx_busy), 32'h1);
    wait_clk(1);
    rst_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    check("t5_rst_busy", 32'(rx_busy), 32'h0);
    check("t5_rst_valid", 32'(rx_valid), 32'h0);
    check("t5_rst_data", 32'(rx_data), 32'h00);
    check("t5_rst_overrun", 32'(overrun), 32'h0);
    check("t5_rst_frame_err", 32'(frame_err), 32'h0);
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(100);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    wait_clk(5);
    @(negedge clk);
    check("t5_count", 32'(got.size()), 32'd1);
    check("t5_data", 32'(got[0]), 32'h81);
    check("t5_frame_err", 32'(frame_err), 32'h0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07 (three ones -> parity bit 1)
    wait_clk(1);
    got.delete();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_clk(5);
    @(negedge clk);
    check("t6_good_count", 32'(got.size()), 32'd1);
    check("t6_good_data", 32'(got[0]), 32'h07);
    check("t6_good_perr", 32'(parity_err), 32'h0);
    wait_clk(1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_clk(5);
    @(negedge clk);
    check("t6_bad_perr", 32'(parity_err), 32'h1);
    check("t6_bad_count", 32'(got.size()), 32'd1);
    wait_clk(1);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("t6_perr_clr", 32'(parity_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
